// File: rtl/bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : bus_arbiter
// Description : Arbitrates an instruction-fetch port and a data port onto one
//               external memory bus using the MREQ/ACK_n handshake. Data beats
//               instruction fetches, except that a fetch pending when a data
//               access completes is granted next (anti-starvation). All external
//               outputs are registered. Back-to-back grants happen on the ACK
//               edge, so consecutive accesses carry no idle cycle.
// Ports       : clk, reset (async, active low)
//               if_req/if_addr  -> if_ready/if_rdata     fetch port
//               dm_req/dm_write/dm_size/dm_addr/dm_wdata
//                               -> dm_ready/dm_rdata     data port
//               bus_err                                  access aborted
//               MAD/MREQ/WRITE/SIZE/MDT_out/MDT_oe, MDT_in, ACK_n  external bus
// Options     : define ARB_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES
//               cycles without ACK_n (bus_err pulses with the ready pulse).
// Revision    : 1.0 - initial release
//==============================================================================
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    // data port
    input  logic        dm_req,
    input  logic        dm_write,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        bus_err,
    // external bus
    output logic [31:0] MAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    output logic [31:0] MDT_out,
    output logic        MDT_oe,
    input  logic [31:0] MDT_in,
    input  logic        ACK_n
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } state_t;

    localparam logic [1:0] C_SIZE_WORD = 2'b10;

    state_t      state_q,    state_d;
    logic        prev_dm_q,  prev_dm_d;   // 1: last grant was DATA
    logic [31:0] mad_q,      mad_d;
    logic        mreq_q,     mreq_d;
    logic        write_q,    write_d;
    logic [1:0]  size_q,     size_d;
    logic [31:0] mdt_out_q,  mdt_out_d;
    logic        mdt_oe_q,   mdt_oe_d;
    logic        if_ready_q, if_ready_d;
    logic        dm_ready_q, dm_ready_d;
    logic        bus_err_q,  bus_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;

    logic busy;
    logic timeout_hit;
    logic done;
    logic grant_pt;
    logic dm_ok;
    logic if_ok;
    logic pick_if;
    logic pick_dm;

    assign busy = (state_q != ST_IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q, wait_cnt_d;
    // Abort on the edge where the wait count would reach TIMEOUT_CYCLES.
    assign timeout_hit = busy & ACK_n & (wait_cnt_q == C_TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // ACK_n is only meaningful while an access is on the bus.
    assign done     = busy & (~ACK_n | timeout_hit);
    assign grant_pt = ~busy | done;

    // A port is not eligible while its own access is still on the bus (its req
    // is still held for that access) nor during its ready cycle.
    assign dm_ok   = dm_req & ~dm_ready_q & (state_q != ST_DATA);
    assign if_ok   = if_req & ~if_ready_q & (state_q != ST_INST);
    assign pick_if = if_ok & (~dm_ok | prev_dm_q);
    assign pick_dm = dm_ok & ~pick_if;

    always_comb begin
        state_d    = state_q;
        prev_dm_d  = prev_dm_q;
        mad_d      = mad_q;
        mreq_d     = mreq_q;
        write_d    = write_q;
        size_d     = size_q;
        mdt_out_d  = mdt_out_q;
        mdt_oe_d   = mdt_oe_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        bus_err_d  = 1'b0;

        if (done) begin
            bus_err_d = timeout_hit;
            if (state_q == ST_DATA) begin
                dm_ready_d = 1'b1;
                if (timeout_hit) begin
                    dm_rdata_d = 32'h0;
                end else if (!write_q) begin
                    dm_rdata_d = MDT_in;
                end
            end else begin
                if_ready_d = 1'b1;
                if_rdata_d = timeout_hit ? 32'h0 : MDT_in;
            end
            state_d  = ST_IDLE;
            mreq_d   = 1'b0;
            write_d  = 1'b0;
            mdt_oe_d = 1'b0;
        end

        if (grant_pt) begin
            if (pick_dm) begin
                state_d   = ST_DATA;
                prev_dm_d = 1'b1;
                mad_d     = dm_addr;
                write_d   = dm_write;
                size_d    = dm_size;
                mdt_out_d = dm_wdata;
                mdt_oe_d  = dm_write;
                mreq_d    = 1'b1;
            end else if (pick_if) begin
                state_d   = ST_INST;
                prev_dm_d = 1'b0;
                mad_d     = if_addr;
                write_d   = 1'b0;
                size_d    = C_SIZE_WORD;
                mdt_oe_d  = 1'b0;
                mreq_d    = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (grant_pt && (pick_dm || pick_if)) begin
            wait_cnt_d = 8'd0;
        end else if (busy && ACK_n) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            prev_dm_q  <= 1'b0;
            mad_q      <= 32'h0;
            mreq_q     <= 1'b0;
            write_q    <= 1'b0;
            size_q     <= C_SIZE_WORD;
            mdt_out_q  <= 32'h0;
            mdt_oe_q   <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            bus_err_q  <= 1'b0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            prev_dm_q  <= prev_dm_d;
            mad_q      <= mad_d;
            mreq_q     <= mreq_d;
            write_q    <= write_d;
            size_q     <= size_d;
            mdt_out_q  <= mdt_out_d;
            mdt_oe_q   <= mdt_oe_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            bus_err_q  <= bus_err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign MAD      = mad_q;
    assign MREQ     = mreq_q;
    assign WRITE    = write_q;
    assign SIZE     = size_q;
    assign MDT_out  = mdt_out_q;
    assign MDT_oe   = mdt_oe_q;
    assign if_ready = if_ready_q;
    assign dm_ready = dm_ready_q;
    assign bus_err  = bus_err_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

endmodule
`default_nettype wire
